// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if
//   Groups the serial input, the output byte handshake and the status flags
//   of serial_frame_rx so they travel as one bundle.
//
//   Handshake: dout_vld=1 means dout holds an unconsumed byte. The byte is
//   consumed on any rising clk edge where dout_vld=1 and out_rdy=1. While
//   dout_vld=1 and out_rdy=0, dout holds its value. out_rdy may be driven
//   independently of dout_vld.
//
//   Signals
//     sin       : serial data bit (from upstream flop)
//     sin_en    : bit strobe, sin is taken on an edge only when sin_en=1
//     out_rdy   : downstream ready
//     dout      : received byte
//     dout_vld  : dout holds an unconsumed byte
//     busy      : receiver is not hunting for sync
//     perr      : one-cycle parity failure pulse
//     ovf       : sticky "good byte dropped" flag
//     state_dbg : current receiver state encoding (0=HUNT, 1=DATA, 2=PAR)
//
//   Modports
//     master : the side that feeds bits and consumes bytes
//     slave  : the receiver itself
interface serial_frame_rx_if;
    logic       sin;
    logic       sin_en;
    logic       out_rdy;
    logic [7:0] dout;
    logic       dout_vld;
    logic       busy;
    logic       perr;
    logic       ovf;
    logic [1:0] state_dbg;

    modport master (
        output sin, sin_en, out_rdy,
        input  dout, dout_vld, busy, perr, ovf, state_dbg
    );

    modport slave (
        input  sin, sin_en, out_rdy,
        output dout, dout_vld, busy, perr, ovf, state_dbg
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Serial frame receiver. Hunts for a 4-bit sync pattern, then collects
//   8 data bits LSB-first and one parity bit. Good bytes are presented on a
//   single-entry output buffer with a valid/ready handshake; parity failures
//   pulse perr, and good bytes that find the buffer full set sticky ovf.
//
//   Parameters
//     SYNC_PAT : sync pattern, oldest bit in the MSB
//     PAR_ODD  : 0 = even parity, 1 = odd parity
//
//   Ports
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : serial_frame_rx_if.slave (sin, sin_en, out_rdy in;
//           dout, dout_vld, busy, perr, ovf, state_dbg out)
module serial_frame_rx #(
    parameter logic [3:0] SYNC_PAT = 4'b1011,
    parameter bit         PAR_ODD  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    serial_frame_rx_if.slave    bus
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] hist, hist_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] data, data_n;
    logic [7:0] dout, dout_n;
    logic       dout_vld, dout_vld_n;
    logic       perr, perr_n;
    logic       ovf, ovf_n;

    logic [3:0] hist_shift;
    logic       par_ok;

    assign hist_shift = {hist[2:0], bus.sin};
    assign par_ok     = ((^data) ^ bus.sin) == PAR_ODD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            hist     <= 4'd0;
            cnt      <= 3'd0;
            data     <= 8'd0;
            dout     <= 8'd0;
            dout_vld <= 1'b0;
            perr     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            hist     <= hist_n;
            cnt      <= cnt_n;
            data     <= data_n;
            dout     <= dout_n;
            dout_vld <= dout_vld_n;
            perr     <= perr_n;
            ovf      <= ovf_n;
        end
    end

    always_comb begin
        state_n    = state;
        hist_n     = hist;
        cnt_n      = cnt;
        data_n     = data;
        dout_n     = dout;
        dout_vld_n = dout_vld;
        perr_n     = 1'b0;
        ovf_n      = ovf;

        // Consumption first; a byte loading on the same edge overrides it.
        if (dout_vld && bus.out_rdy) begin
            dout_vld_n = 1'b0;
        end

        if (bus.sin_en) begin
            case (state)
                HUNT: begin
                    hist_n = hist_shift;
                    if (hist_shift == SYNC_PAT) begin
                        state_n = DATA;
                        cnt_n   = 3'd0;
                        data_n  = 8'd0;
                    end
                end
                DATA: begin
                    data_n[cnt] = bus.sin;
                    cnt_n       = 3'(cnt + 3'd1);
                    if (cnt == 3'd7) begin
                        state_n = PAR;
                    end
                end
                PAR: begin
                    state_n = HUNT;
                    // History restarts empty so sync cannot borrow frame bits.
                    hist_n  = 4'd0;
                    if (!par_ok) begin
                        perr_n = 1'b1;
                    end else if (!dout_vld || bus.out_rdy) begin
                        dout_n     = data;
                        dout_vld_n = 1'b1;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
                default: begin
                    state_n = HUNT;
                    hist_n  = 4'd0;
                end
            endcase
        end
    end

    assign bus.dout      = dout;
    assign bus.dout_vld  = dout_vld;
    assign bus.busy      = (state != HUNT);
    assign bus.perr      = perr;
    assign bus.ovf       = ovf;
    assign bus.state_dbg = state;

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 The block SHALL have parameter SYNC_PAT, default 4'b1011, the sync pattern that must precede each frame, compared as the last four accepted bits in arrival order with the oldest bit as MSB.
REQ-002 The block SHALL have parameter PAR_ODD, default 0, selecting the parity mode: 0 = even parity, 1 = odd parity.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: a synchronous, active-high reset.
REQ-005 The block SHALL have port SIN, input, 1 bit: the serial data bit, taken from an upstream D flip-flop Q output.
REQ-006 The block SHALL have port SIN_EN, input, 1 bit: the bit strobe, meaning SIN is accepted on a rising CLK edge only when SIN_EN=1.
REQ-007 The block SHALL have port OUT_RDY, input, 1 bit: the downstream-ready signal.
REQ-008 The block SHALL have port DOUT, output, 8 bits: the received data byte.
REQ-009 The block SHALL have port DOUT_VLD, output, 1 bit: high when DOUT holds an unconsumed byte.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high whenever the FSM is not in HUNT.
REQ-011 The block SHALL have port PERR, output, 1 bit: a one-cycle pulse that flags a parity failure.
REQ-012 The block SHALL have port OVF, output, 1 bit: a sticky flag set when a good byte is dropped because the output buffer is full.

Function
REQ-013 The FSM SHALL have exactly three states: HUNT, DATA and PAR.
REQ-014 In HUNT, each accepted bit SHALL shift into a 4-bit history register, and the FSM SHALL move to DATA on the edge where {history[2:0],SIN} equals SYNC_PAT.
REQ-015 On entering DATA, the block SHALL clear the bit counter (3 bits) and the shift register.
REQ-016 In DATA, the block SHALL accept 8 bits LSB-first: bit k (k = 0..7) goes to data[k], and the counter increments on each accepted bit.
REQ-017 The FSM SHALL move from DATA to PAR on the edge that accepts bit 7, with the counter wrapping from 7 to 0.
REQ-018 In PAR, the block SHALL accept one parity bit; the parity check passes when (^data ^ parity_bit) == PAR_ODD.
REQ-019 After accepting the parity bit, the FSM SHALL return to HUNT and clear the history register, so sync bits cannot overlap the previous frame.
REQ-020 While SIN_EN=0, all FSM, counter and shift state SHALL hold, with no timeout.
REQ-021 On a parity failure, the block SHALL pulse PERR for exactly the cycle after the parity edge and discard the byte; DOUT, DOUT_VLD and OVF SHALL be unaffected.
REQ-022 On a parity pass with the buffer empty (DOUT_VLD=0), or with the buffer being consumed in the same cycle (DOUT_VLD=1 and OUT_RDY=1), the block SHALL load DOUT and hold DOUT_VLD=1 from the next cycle.
REQ-023 On a parity pass with DOUT_VLD=1 and OUT_RDY=0, the block SHALL drop the new byte, keep DOUT unchanged, and set OVF, which stays set until RST.
REQ-024 A byte SHALL be consumed on any edge where DOUT_VLD=1 and OUT_RDY=1; DOUT_VLD clears unless a new byte loads on the same edge.
REQ-025 DOUT SHALL remain stable while DOUT_VLD=1 and OUT_RDY=0.
REQ-026 Latency SHALL be exactly one cycle from the parity-bit accepting edge to DOUT_VLD=1.
REQ-027 A new sync pattern SHALL be searchable starting with the bit immediately after the parity bit, with no dead cycles.

Reset
REQ-028 When RST=1 at a rising CLK edge, the block SHALL force the FSM to HUNT and clear the history register, counter and shift register.
REQ-029 When RST=1 at a rising CLK edge, the block SHALL set DOUT=8'h00, DOUT_VLD=0, PERR=0, OVF=0 and BUSY=0.
REQ-030 RST SHALL take priority over SIN_EN and OUT_RDY.
REQ-031 If RST is asserted mid-frame, the partial byte SHALL be discarded with no PERR pulse.
REQ-032 No output SHALL change asynchronously to CLK.

Verification
REQ-033 Good frame: hold OUT_RDY=1, send bits 1,0,1,1 then 0xA5 LSB-first (1,0,1,0,0,1,0,1) then even parity 0 -> one cycle after the parity edge, DOUT=8'hA5 and DOUT_VLD=1; PERR=0 and OVF=0; DOUT_VLD drops after one cycle.
REQ-034 Parity error: send the same frame with parity bit 1 -> PERR pulses high for one cycle, DOUT_VLD stays 0, DOUT stays 8'h00, and the FSM returns to HUNT.
REQ-035 Overflow: hold OUT_RDY=0 and send good frames 0x3C then 0xC3 -> DOUT=8'h3C, DOUT_VLD=1 and OVF=1; then raise OUT_RDY for one cycle -> DOUT_VLD=0 while OVF stays 1.
REQ-036 Strobe gaps: insert random SIN_EN=0 gaps of 0-5 cycles into a 0x5A frame -> DOUT=8'h5A is received correctly.
REQ-037 Sync hunting: send 1,1,0,1,1 followed by data 0xFF with parity 0 -> sync is detected on the fifth bit and DOUT=8'hFF.
REQ-038 Reset mid-frame: assert RST for one cycle after 4 data bits, then send a full 0x81 frame -> exactly one byte appears, DOUT=8'h81, with PERR=0 and OVF=0 throughout.
